product_inventory: RTL and testbench
====================================

PRODUCT_INVENTORY -- requirements
Module: product_inventory

Interface
REQ-001 Parameter N_PROD, default 10: number of product slots, range 1..15.
REQ-002 Parameter CNT_W, default 4: stock counter width per slot.
REQ-003 Parameter INIT_CNT, default 0: stock value loaded into every slot on reset; SHALL be <= 2^CNT_W-1.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-005 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_prod  in  4  product number, 1-based; valid range 1..N_PROD.
REQ-009 req_op  in  2  operation: 00 query, 01 dispense, 10 restock, 11 reserved.
REQ-010 req_qty  in  CNT_W  quantity for dispense or restock; ignored for query.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  consumer accepts the response.
REQ-013 resp_in_stock  out  1  slot count > 0 after the operation.
REQ-014 resp_count  out  CNT_W  slot count after the operation.
REQ-015 resp_err  out  2  error code: 00 ok, 01 bad product or op, 10 insufficient stock, 11 restock saturated.
REQ-016 empty_mask  out  N_PROD  bit i-1 high when slot i count == 0; registered.

Function
REQ-017 FSM states SHALL be IDLE, LOOKUP, UPDATE, RESP.
REQ-018 req_ready SHALL be high only in IDLE.
REQ-019 Acceptance SHALL occur when req_valid && req_ready; req_prod, req_op and req_qty SHALL be captured on that edge.
REQ-020 Transitions SHALL be: IDLE->LOOKUP on accept; LOOKUP->UPDATE unconditionally; UPDATE->RESP unconditionally; RESP->IDLE when resp_ready.
REQ-021 LOOKUP SHALL read the captured slot's count into a holding register and SHALL classify errors.
REQ-022 Errors SHALL be classified as: req_prod == 0, req_prod > N_PROD, or req_op == 11 -> err 01, count 0, in_stock 0, no slot modified.
REQ-023 Dispense: qty <= count -> count := count - qty, err 00; qty > count -> no change, err 10.
REQ-024 Restock: count + qty SHALL be computed at CNT_W+1 bits; overflow -> count := 2^CNT_W-1, err 11; otherwise sum, err 00.
REQ-025 Query SHALL leave the count unchanged, err 00.
REQ-026 A dispense or restock with qty == 0 SHALL be legal, SHALL leave the count unchanged, and SHALL report err 00.
REQ-027 The slot write SHALL occur on the UPDATE->RESP edge.
REQ-028 empty_mask SHALL reflect the write on the same edge.
REQ-029 resp_valid SHALL be high exactly in RESP.
REQ-030 resp_* outputs SHALL be stable while resp_valid && !resp_ready.
REQ-031 Accept-to-resp_valid latency SHALL be 3 cycles.
REQ-032 Minimum request-to-request spacing SHALL be 4 cycles, with resp_ready held high.
REQ-033 req_valid outside IDLE SHALL be ignored and SHALL NOT be lost-tracked; the requester holds it until req_ready.
REQ-034 Slots other than the addressed one SHALL never change.

Reset
REQ-035 On rst high at a clock edge, the FSM SHALL go to IDLE and every slot SHALL load INIT_CNT.
REQ-036 On the same reset edge, empty_mask SHALL be all ones if INIT_CNT == 0, else all zeros.
REQ-037 On the same reset edge, resp_valid SHALL be 0, resp_count SHALL be 0, resp_err SHALL be 00, and resp_in_stock SHALL be 0.
REQ-038 req_ready SHALL be 1 in the cycle after reset.
REQ-039 Reset mid-transaction in LOOKUP, UPDATE or RESP SHALL abort the transaction with no slot write and no response.
REQ-040 Reset SHALL take priority over every other input.

Verification
REQ-041 Defaults, reset, then restock prod 3 qty 5 -> resp_valid 3 cycles after accept, count 5, err 00, empty_mask bit2 = 0.
REQ-042 Prod 3 holding 5, dispense qty 5 -> count 0, in_stock 0, err 00, empty_mask bit2 = 1; a following dispense qty 1 -> err 10, count 0.
REQ-043 Prod 7 holding 12, restock qty 9 -> count 15, err 11; then query -> count 15, err 00.
REQ-044 Requests with prod 0, prod 11 and op 11 -> each err 01, empty_mask and all slots unchanged.
REQ-045 resp_ready held low 5 cycles in RESP -> resp_* stable and req_ready low throughout; rst asserted in UPDATE -> no write, all slots INIT_CNT, resp_valid 0.

Source files
------------

// File: rtl/product_inventory.sv
// Per-slot stock counter bank behind a valid/ready request port.
// Each request walks IDLE -> LOOKUP -> UPDATE -> RESP; only the addressed slot is written.
module product_inventory #(
  parameter int N_PROD   = 10,
  parameter int CNT_W    = 4,
  parameter int INIT_CNT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_prod,
  input  logic [1:0]        req_op,
  input  logic [CNT_W-1:0]  req_qty,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_in_stock,
  output logic [CNT_W-1:0]  resp_count,
  output logic [1:0]        resp_err,
  output logic [N_PROD-1:0] empty_mask
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_e;

  localparam logic [1:0] OP_DISPENSE = 2'b01;
  localparam logic [1:0] OP_RESTOCK  = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_BAD   = 2'b01;
  localparam logic [1:0] ERR_SHORT = 2'b10;
  localparam logic [1:0] ERR_SAT   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);

  state_e              state_q;
  logic [3:0]          prod_q;
  logic [1:0]          op_q;
  logic [CNT_W-1:0]    qty_q;
  logic [CNT_W-1:0]    hold_q;
  logic                bad_q;
  logic [CNT_W-1:0]    cnt_q [N_PROD];
  logic [N_PROD-1:0]   empty_q;
  logic                ready_q;
  logic                resp_valid_q;
  logic                resp_in_stock_q;
  logic [CNT_W-1:0]    resp_count_q;
  logic [1:0]          resp_err_q;

  logic [CNT_W-1:0]    rd_cnt_d;
  logic                bad_d;
  logic [CNT_W:0]      sum_d;
  logic [CNT_W-1:0]    new_cnt_d;
  logic [1:0]          new_err_d;

  // Read mux over the slots; an out-of-range product simply reads zero.
  always_comb begin
    rd_cnt_d = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (prod_q == 4'(i + 1)) rd_cnt_d = cnt_q[i];
    end
    bad_d = (prod_q == 4'd0) || (prod_q > 4'(N_PROD)) || (op_q == OP_RSVD);
  end

  // Result of the operation on the held count; the extra sum bit flags restock overflow.
  always_comb begin
    sum_d     = {1'b0, hold_q} + {1'b0, qty_q};
    new_cnt_d = hold_q;
    new_err_d = ERR_OK;
    if (bad_q) begin
      new_cnt_d = '0;
      new_err_d = ERR_BAD;
    end else begin
      case (op_q)
        OP_DISPENSE: begin
          if (qty_q > hold_q) new_err_d = ERR_SHORT;
          else                new_cnt_d = hold_q - qty_q;
        end
        OP_RESTOCK: begin
          if (sum_d[CNT_W]) begin
            new_cnt_d = CNT_MAX;
            new_err_d = ERR_SAT;
          end else begin
            new_cnt_d = sum_d[CNT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      ready_q         <= 1'b1;
      prod_q          <= '0;
      op_q            <= '0;
      qty_q           <= '0;
      hold_q          <= '0;
      bad_q           <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_in_stock_q <= 1'b0;
      resp_count_q    <= '0;
      resp_err_q      <= ERR_OK;
      // NOTE: the slot array is small and must come up at INIT_CNT, so it is reset like any register.
      for (int i = 0; i < N_PROD; i++) cnt_q[i] <= INIT_VAL;
      empty_q         <= (INIT_VAL == '0) ? '1 : '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            prod_q  <= req_prod;
            op_q    <= req_op;
            qty_q   <= req_qty;
            ready_q <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          hold_q  <= rd_cnt_d;
          bad_q   <= bad_d;
          state_q <= UPDATE;
        end
        UPDATE: begin
          if (!bad_q) begin
            for (int i = 0; i < N_PROD; i++) begin
              if (prod_q == 4'(i + 1)) begin
                cnt_q[i]   <= new_cnt_d;
                empty_q[i] <= (new_cnt_d == '0);
              end
            end
          end
          resp_count_q    <= new_cnt_d;
          resp_err_q      <= new_err_d;
          resp_in_stock_q <= (new_cnt_d != '0);
          resp_valid_q    <= 1'b1;
          state_q         <= RESP;
        end
        RESP: begin
          // Response registers are left untouched here, so they hold through back-pressure.
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_in_stock = resp_in_stock_q;
  assign resp_count    = resp_count_q;
  assign resp_err      = resp_err_q;
  assign empty_mask    = empty_q;

endmodule

// File: tb/tb_product_inventory.sv
// Directed bench for product_inventory: stimulus pushes hand-computed responses into a
// scoreboard queue, a monitor pops and compares on every response handshake.
module tb_product_inventory;

  localparam int N_PROD = 10;
  localparam int CNT_W  = 4;

  localparam logic [1:0] Q  = 2'b00;
  localparam logic [1:0] DI = 2'b01;
  localparam logic [1:0] RS = 2'b10;
  localparam logic [1:0] RV = 2'b11;

  localparam logic [1:0] OK    = 2'b00;
  localparam logic [1:0] BAD   = 2'b01;
  localparam logic [1:0] SHORT = 2'b10;
  localparam logic [1:0] SAT   = 2'b11;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        err;
    logic              in_stock;
    logic [N_PROD-1:0] mask;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_prod;
  logic [1:0]        req_op;
  logic [CNT_W-1:0]  req_qty;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_in_stock;
  logic [CNT_W-1:0]  resp_count;
  logic [1:0]        resp_err;
  logic [N_PROD-1:0] empty_mask;

  exp_t              sb[$];
  logic [N_PROD-1:0] exp_mask;
  int                n_chk = 0;
  int                n_err = 0;

  product_inventory #(.N_PROD(N_PROD), .CNT_W(CNT_W), .INIT_CNT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_prod     (req_prod),
    .req_op       (req_op),
    .req_qty      (req_qty),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_in_stock(resp_in_stock),
    .resp_count   (resp_count),
    .resp_err     (resp_err),
    .empty_mask   (empty_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is consumed when valid and ready are both seen mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_count", 32'(resp_count), 32'(e.cnt));
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_in_stock", 32'(resp_in_stock), 32'(e.in_stock));
          check("empty_mask", 32'(empty_mask), 32'(e.mask));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [3:0] prod, input logic [1:0] op, input logic [CNT_W-1:0] qty,
                        input logic [CNT_W-1:0] exp_cnt, input logic [1:0] exp_err, input bit stall);
    exp_t e;
    int   lat;
    bit   got;
    if (exp_err != BAD) exp_mask[int'(prod) - 1] = (exp_cnt == '0);
    e.cnt      = exp_cnt;
    e.err      = exp_err;
    e.in_stock = (exp_cnt != '0);
    e.mask     = exp_mask;
    sb.push_back(e);

    @(posedge clk); #1;
    resp_ready = !stall;
    req_valid  = 1'b1;
    req_prod   = prod;
    req_op     = op;
    req_qty    = qty;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; break; end
    end
    check("req_ready_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    lat = 0;
    for (int i = 0; i < 10; i++) begin
      lat++;
      @(negedge clk);
      if (resp_valid) break;
    end
    check("accept_to_valid_latency", 32'(lat), 32'd3);

    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        check("stall_resp_valid", 32'(resp_valid), 32'd1);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_resp_count", 32'(resp_count), 32'(exp_cnt));
        check("stall_resp_err", 32'(resp_err), 32'(exp_err));
        @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end

    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("response_consumed", 32'(got), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_prod   = '0;
    req_op     = '0;
    req_qty    = '0;
    resp_ready = 1'b1;
    exp_mask   = '1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_count", 32'(resp_count), 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    check("reset_in_stock", 32'(resp_in_stock), 32'd0);
    check("reset_empty_mask", 32'(empty_mask), 32'h3FF);

    do_req(4'd3,  RS, 4'd5,  4'd5,  OK,    1'b0);
    do_req(4'd3,  DI, 4'd5,  4'd0,  OK,    1'b0);
    do_req(4'd3,  DI, 4'd1,  4'd0,  SHORT, 1'b0);
    do_req(4'd7,  RS, 4'd12, 4'd12, OK,    1'b0);
    do_req(4'd7,  RS, 4'd9,  4'd15, SAT,   1'b0);
    do_req(4'd7,  Q,  4'd0,  4'd15, OK,    1'b0);
    do_req(4'd0,  Q,  4'd0,  4'd0,  BAD,   1'b0);
    do_req(4'd11, RS, 4'd3,  4'd0,  BAD,   1'b0);
    do_req(4'd7,  RV, 4'd1,  4'd0,  BAD,   1'b0);
    do_req(4'd7,  Q,  4'd4,  4'd15, OK,    1'b0);
    do_req(4'd7,  DI, 4'd0,  4'd15, OK,    1'b0);
    do_req(4'd1,  RS, 4'd0,  4'd0,  OK,    1'b0);
    do_req(4'd10, RS, 4'd15, 4'd15, OK,    1'b0);
    do_req(4'd10, DI, 4'd15, 4'd0,  OK,    1'b0);
    do_req(4'd5,  RS, 4'd4,  4'd4,  OK,    1'b1);

    // Reset while the request sits in UPDATE: the write and response must both vanish.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_prod  = 4'd5;
    req_op    = RS;
    req_qty   = 4'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_mask = '1;
    @(negedge clk);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_empty_mask", 32'(empty_mask), 32'h3FF);
    check("abort_resp_count", 32'(resp_count), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_response", 32'(resp_valid), 32'd0);
    end

    do_req(4'd5,  Q, 4'd0, 4'd0, OK, 1'b0);
    do_req(4'd7,  Q, 4'd0, 4'd0, OK, 1'b0);
    do_req(4'd10, Q, 4'd0, 4'd0, OK, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
